// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers. Each op takes DATA_WIDTH+1 cycles.
// Define MDU_DIV_EN to build the restoring divider. Otherwise DIV/DIVU complete with an error.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mtHi,
  input  logic                  mtLo,
  input  logic [DATA_WIDTH-1:0] mtData,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int unsigned W = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;
  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;   // product high half, or partial remainder
  logic [W-1:0]    mq_q, mq_d;     // multiplier -> product low half, or dividend -> quotient
  logic [W-1:0]    opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d; // negate product, or quotient
  logic            err_q, err_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d, error_q, error_d;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    add_sum;
  logic [2*W-1:0] prod, prod_res;

  assign a_neg = ~op[0] & a[W-1];
  assign b_neg = ~op[0] & b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign add_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(W + 1){1'b0}});
  assign prod     = {acc_q, mq_q};
  assign prod_res = neg_lo_q ? -prod : prod;

`ifdef MDU_DIV_EN
  logic         neg_hi_q, neg_hi_d; // remainder takes the dividend's sign
  logic [W:0]   shifted;
  logic [W+1:0] diff;

  assign shifted = {acc_q, mq_q[W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, opnd_q};
`endif

  assign ready = (state_q == StIdle);
  assign done  = done_q;
  assign error = error_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    err_d    = err_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef MDU_DIV_EN
    neg_hi_d = neg_hi_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mtHi) hi_d = mtData;
        if (mtLo) lo_d = mtData;
        if (start) begin
          is_div_d = op[1];
          neg_lo_d = a_neg ^ b_neg;
          acc_d    = '0;
          mq_d     = op[1] ? a_mag : b_mag;
          opnd_d   = op[1] ? b_mag : a_mag;
          cnt_d    = CntLoad;
          state_d  = StRun;
`ifdef MDU_DIV_EN
          neg_hi_d = a_neg;
          err_d    = op[1] && (b == '0);
`else
          err_d    = op[1];
          if (op[1]) state_d = StFix;
`endif
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
        acc_d = add_sum[W:1];
        mq_d  = {add_sum[0], mq_q[W-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          acc_d = diff[W+1] ? shifted[W-1:0] : diff[W-1:0];
          mq_d  = {mq_q[W-2:0], ~diff[W+1]};
        end
`endif
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        error_d = err_q;
        if (!is_div_q) begin
          hi_d = prod_res[2*W-1:W];
          lo_d = prod_res[W-1:0];
        end
`ifdef MDU_DIV_EN
        else begin
          // Divide by zero leaves |a| in the remainder, so re-signing it yields a.
          hi_d = neg_hi_q ? -acc_q : acc_q;
          lo_d = err_q ? '1 : (neg_lo_q ? -mq_q : mq_q);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      err_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      err_q    <= err_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) neg_hi_q <= 1'b0;
    else          neg_hi_q <= neg_hi_d;
  end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/error/completion cycle are queued at issue
// and checked by an independent monitor on every done pulse.
module tb_mult_div_unit;
  localparam int unsigned W = 32;
  localparam int Lat = W + 1;
`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        mt_hi = 1'b0;
  logic        mt_lo = 1'b0;
  logic [31:0] mt_data = '0;
  logic        ready, done, error;
  logic [31:0] hi, lo;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mtHi   (mt_hi),
    .mtLo   (mt_lo),
    .mtData (mt_data),
    .ready  (ready),
    .done   (done),
    .error  (error),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          stray_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (error && !done) stray_err = 1'b1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result_hi", {32'd0, hi}, {32'd0, e.hi});
          check("result_lo", {32'd0, lo}, {32'd0, e.lo});
          check("result_error", {63'd0, error}, {63'd0, e.err});
          check("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic issue_mt(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic mh, input logic ml, input logic [31:0] md);
    int          g = 0;
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, p;
    while (!ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (!ready) begin
      check("ready_timeout", {63'd0, ready}, 64'd1);
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    mt_hi = mh; mt_lo = ml; mt_data = md;
    if (mh) m_hi = md;
    if (ml) m_lo = md;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    e.err = 1'b0;
    e.due = cyc + 1 + Lat;
    if (!o[1]) begin
      if (o[0]) p = ux * uy;
      else      p = sx * sy;
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (!DivEn) begin
      e.err = 1'b1;
      e.due = cyc + 2;
    end else if (y == 32'd0) begin
      e.err = 1'b1;
      m_hi  = x;
      m_lo  = 32'hFFFF_FFFF;
    end else if (o[0]) begin
      p = ux / uy; m_lo = p[31:0];
      p = ux % uy; m_hi = p[31:0];
    end else begin
      q = sx / sy; m_lo = q[31:0];
      r = sx % sy; m_hi = r[31:0];
    end
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue_mt(o, x, y, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clock);
      g++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clock);
  endtask

  task automatic mt_write(input logic mh, input logic ml, input logic [31:0] md);
    mt_hi = mh; mt_lo = ml; mt_data = md;
    if (mh) m_hi = md;
    if (ml) m_lo = md;
    @(negedge clock);
    mt_hi = 1'b0; mt_lo = 1'b0;
    check("mt_hi_value", {32'd0, hi}, {32'd0, m_hi});
    check("mt_lo_value", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    int e0;
    bit busy_bad;
    repeat (3) @(negedge clock);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_error", {63'd0, error}, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // Full-width unsigned product, with ready held low through the whole operation.
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e0 = cyc;
    busy_bad = 1'b0;
    while (cyc < e0 + Lat) begin
      if (ready) busy_bad = 1'b1;
      @(negedge clock);
    end
    check("ready_low_while_busy", {63'd0, busy_bad}, 64'd0);
    check("ready_after_done", {63'd0, ready}, 64'd1);

    // Directed corner cases, issued back to back.
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd3, 32'd5, 32'd0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE);
    issue(2'd2, 32'hFFFF_FFFB, 32'd0);
    issue(2'd1, 32'd0, 32'h1234_5678);
    issue(2'd3, 32'hFFFF_FFFF, 32'd1);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000);

    // mt write in the same cycle as an accepted start lands first, result overwrites later.
    issue_mt(2'd0, 32'd100, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hA5A5_0000);
    check("mt_with_start_hi", {32'd0, hi}, 64'hA5A5_0000);
    check("mt_with_start_lo", {32'd0, lo}, 64'hA5A5_0000);
    drain();

    // start and mtHi while busy are both ignored.
    mt_write(1'b1, 1'b0, 32'hCAFE_0000);
    issue(2'd1, 32'd3, 32'd5);
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
    mt_hi = 1'b1; mt_data = 32'h0000_1234;
    @(negedge clock);
    start = 1'b0; mt_hi = 1'b0;
    check("run_mthi_ignored", {32'd0, hi}, 64'hCAFE_0000);
    check("run_ready_low", {63'd0, ready}, 64'd0);
    drain();
    repeat (40) @(negedge clock);
    mt_write(1'b1, 1'b0, 32'h0000_1234);

    // Reset in the tenth RUN cycle abandons the op without a done pulse.
    issue(2'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_hi", {32'd0, hi}, 64'd0);
    check("midrun_reset_lo", {32'd0, lo}, 64'd0);
    check("midrun_reset_ready", {63'd0, ready}, 64'd1);
    check("midrun_reset_done", {63'd0, done}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    issue(2'd1, 32'd6, 32'd7);
    drain();
    check("after_reset_lo", {32'd0, lo}, 64'd42);
    check("after_reset_hi", {32'd0, hi}, 64'd0);

    // Randomised ops, some carrying a simultaneous mt write.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        issue_mt(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom());
      else
        issue(2'($urandom_range(0, 3)), pick(), pick());
    end
    drain();

    check("no_error_without_done", {63'd0, stray_err}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
